ssr_peak_timing: RTL
====================

SSR_PEAK_TIMING -- requirements
Module: ssr_peak_timing

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16: half-width of each correlator magnitude word.
REQ-002 SHALL have parameter PHASES, default 64: parallel phases per clock; power of two only.
REQ-003 SHALL have parameter OUTBITS, default $clog2(PHASES): width of the argmax phase index.
REQ-004 SHALL have parameter CNTBITS, default 16: width of the valid-cycle counter.
REQ-005 SHALL have parameter WINDOW, default 64: number of valid cycles tracked after the first threshold crossing.
REQ-006 SHALL have parameter MAX_WAIT, default 4096: number of valid cycles before a timeout while waiting for a crossing.
REQ-007 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-008 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port start_i, input, 1 bit: arms a new search; sampled in IDLE only.
REQ-010 SHALL have port valid_i, input, 1 bit: the argmax pair is valid this cycle.
REQ-011 SHALL have port index_max_i, input, OUTBITS bits: winning phase from the argmax tree.
REQ-012 SHALL have port value_max_i, input, 2*DATAWIDTH bits: winning magnitude, unsigned.
REQ-013 SHALL have port threshold_i, input, 2*DATAWIDTH bits: detection threshold, unsigned; latched at start.
REQ-014 SHALL have port timing_o, output, CNTBITS+OUTBITS bits: peak sample offset, {cycle count, phase index}.
REQ-015 SHALL have port peak_o, output, 2*DATAWIDTH bits: magnitude of the reported peak.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle pulse; timing_o and peak_o are valid.
REQ-017 SHALL have port timeout_o, output, 1 bit: one-cycle pulse; the search expired without a crossing.
REQ-018 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, TRACK and DONE; encoding is free.
REQ-020 IDLE: on start_i=1, SHALL latch threshold_i, clear the cycle counter, and go to WAIT on the next clock.
REQ-021 The cycle counter SHALL increment once per valid_i=1 cycle in WAIT and TRACK, and SHALL saturate at all-ones.
REQ-022 The counter value tagged to an input SHALL be its count before the increment; the first valid input after start is cycle 0.
REQ-023 WAIT: on valid_i=1 with value_max_i > the latched threshold (strict), SHALL capture the value, {count, index} and go to TRACK.
REQ-024 TRACK: SHALL replace the capture only when value_max_i is strictly greater than the held peak, so ties keep the earliest peak.
REQ-025 TRACK: SHALL count valid cycles including the crossing cycle; after WINDOW of them, SHALL go to DONE.
REQ-026 TRACK: the cycle that completes WINDOW SHALL itself be compared before the transition.
REQ-027 DONE: SHALL assert done_o for exactly one cycle with timing_o and peak_o stable, then return to IDLE.
REQ-028 timing_o and peak_o SHALL hold their last result until the next crossing is captured.
REQ-029 valid_i=0 cycles SHALL be ignored; they do not advance the counter, the window or the timeout.
REQ-030 start_i asserted outside IDLE SHALL be ignored.
REQ-031 Timing: end-to-end latency from the final contributing input to done_o SHALL be 2 clocks.

Reset
REQ-032 On rst_i=0, SHALL asynchronously force state IDLE and clear all of the following to 0: counter, window count, latched threshold, timing_o, peak_o, done_o, timeout_o and busy_o.
REQ-033 Reset asserted mid-search SHALL abort the search with no done_o or timeout_o pulse.
REQ-034 The first start_i SHALL be honoured on the first clock after rst_i deasserts.

Configuration
REQ-035 SHALL support macro SSR_PEAK_TIMEOUT_EN.
REQ-036 With SSR_PEAK_TIMEOUT_EN defined: after MAX_WAIT valid cycles in WAIT with no crossing, SHALL pulse timeout_o for 1 cycle and return to IDLE; timing_o and peak_o are unchanged.
REQ-037 Without SSR_PEAK_TIMEOUT_EN: WAIT SHALL persist indefinitely and timeout_o SHALL be tied to 0.

Verification
REQ-038 Basic: threshold=100, WINDOW=4; valid inputs (val,idx) = (50,3),(120,5),(300,9),(200,1),(310,2) -> done_o with peak_o=310, timing_o={4,2}.
REQ-039 Tie: threshold=10; in TRACK, (500,7) at cycle 2 then (500,1) at cycle 3 -> timing_o={2,7}.
REQ-040 Gaps: a crossing at cycle 0 with valid_i low for 10 cycles in between -> done_o only after WINDOW valid cycles; timing_o counts valid cycles only.
REQ-041 Timeout: SSR_PEAK_TIMEOUT_EN defined, MAX_WAIT=8, all values below threshold -> timeout_o pulses after the 8th valid cycle, busy_o falls, and outputs are unchanged.
REQ-042 Reset: rst_i=0 during TRACK -> busy_o=0 immediately, no done_o; a new start gives a correct result.
REQ-043 Boundary: threshold equal to value_max_i -> no crossing; start_i held high during TRACK -> no restart.

Source files
------------

// File: rtl/ssr_peak_timing.sv
// Peak-timing search over an argmax stream: arm, wait for a threshold crossing,
// track the largest peak over WINDOW valid cycles, report {cycle, phase}.
// Optional macro SSR_PEAK_TIMEOUT_EN adds a MAX_WAIT valid-cycle timeout while waiting.
module ssr_peak_timing #(
  parameter int DATAWIDTH = 16,
  parameter int PHASES    = 64,
  parameter int OUTBITS   = $clog2(PHASES),
  parameter int CNTBITS   = 16,
  parameter int WINDOW    = 64,
  parameter int MAX_WAIT  = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       valid_i,
  input  logic [OUTBITS-1:0]         index_max_i,
  input  logic [2*DATAWIDTH-1:0]     value_max_i,
  input  logic [2*DATAWIDTH-1:0]     threshold_i,
  output logic [CNTBITS+OUTBITS-1:0] timing_o,
  output logic [2*DATAWIDTH-1:0]     peak_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic                       busy_o
);

  localparam int WMAX = (WINDOW > MAX_WAIT) ? WINDOW : MAX_WAIT;
  localparam int WCW  = $clog2(WMAX + 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, WAIT, TRACK, DONE} state_t;

  state_t                 state;
  logic [CNTBITS-1:0]     cnt;
  logic [CNTBITS-1:0]     cnt_nxt;
  logic [WCW-1:0]         wcnt;
  logic [2*DATAWIDTH-1:0] thr;

  // Saturating valid-cycle count; the pre-increment value tags the sample.
  assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      thr       <= '0;
      timing_o  <= '0;
      peak_o    <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            thr    <= threshold_i;
            cnt    <= '0;
            wcnt   <= '0;
            state  <= WAIT;
            busy_o <= 1'b1;
          end
        end
        WAIT: begin
          if (valid_i) begin
            cnt <= cnt_nxt;
            if (value_max_i > thr) begin
              peak_o   <= value_max_i;
              timing_o <= {cnt, index_max_i};
              wcnt     <= WCW'(1);
              // The crossing cycle counts toward the window.
              state    <= (WINDOW == 1) ? DONE : TRACK;
            end
`ifdef SSR_PEAK_TIMEOUT_EN
            else if (wcnt == WCW'(MAX_WAIT - 1)) begin
              timeout_o <= 1'b1;
              state     <= IDLE;
              busy_o    <= 1'b0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
`endif
          end
        end
        TRACK: begin
          if (valid_i) begin
            cnt <= cnt_nxt;
            // Strict compare keeps the earliest of equal peaks.
            if (value_max_i > peak_o) begin
              peak_o   <= value_max_i;
              timing_o <= {cnt, index_max_i};
            end
            if (wcnt == WIN_LAST) state <= DONE;
            else                  wcnt  <= wcnt + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
